cpu_clock_controller: RTL and testbench

Sequences execution of the lab processor by producing a single-cycle clock-enable pulse (`cpu_en`) from the board clock. It supports three behaviours. In continuous run mode the pulse rate is set by a programmable divisor. In single-step mode one pulse is issued per debounced button press. A halt request from the CPU freezes execution until `resume`. The block sits between the board clock/switches and the processor's register-enable inputs, and replaces free-running divided clocks with one clock domain plus enables.

---
 rtl/cpu_clk_pkg.sv | 18 +
 rtl/cpu_clock_controller_if.sv | 28 ++
 rtl/step_debouncer.sv | 57 +++++
 rtl/cpu_clock_controller.sv | 113 +++++++++++
 tb/tb_cpu_clock_controller.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock-enable controller and its helpers.
package cpu_clk_pkg;

    // Controller state encoding, also driven straight out on the state port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    // Smallest divisor that keeps cpu_en from ever being high two cycles in a row.
    localparam int MIN_DIV = 2;

    // Width of the issued-pulse counter.
    localparam int EN_CNT_W = 16;

endpackage

// File: rtl/cpu_clock_controller_if.sv
// Board-side control and status signals of the CPU clock-enable controller.
interface cpu_clock_controller_if
    import cpu_clk_pkg::*;
#(
    parameter int CNT_WIDTH = 28
);
    logic                 run_sw;
    logic                 step_btn;
    logic                 halt_req;
    logic                 resume;
    logic [CNT_WIDTH-1:0] div_value;
    logic                 div_load;
    logic                 cpu_en;
    logic [1:0]           state;
    logic [EN_CNT_W-1:0]  en_count;

    // Board / CPU side: drives the controls, observes the enable and status.
    modport master (
        output run_sw, step_btn, halt_req, resume, div_value, div_load,
        input  cpu_en, state, en_count
    );

    // Controller side.
    modport slave (
        input  run_sw, step_btn, halt_req, resume, div_value, div_load,
        output cpu_en, state, en_count
    );
endinterface

// File: rtl/step_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability filter and
// rising-edge detect producing a single-cycle pulse per accepted press.
module step_debouncer #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic btn_raw,
    output logic step_pulse
);
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pulse_q, pulse_d;

    // Accept a new level only after it has differed from the stable level for DB_CYCLES cycles.
    always_comb begin
        // NOTE: every _d gets a default first so no path through the block can infer a latch.
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = '0;
        pulse_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Synchronizer, filter and edge registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, giving a true shift chain.
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign step_pulse = pulse_q;

endmodule

// File: rtl/cpu_clock_controller.sv
// Produces the processor clock-enable pulse: free-running divided rate in RUN,
// one pulse per debounced button press in STEP, frozen while HALTED.
module cpu_clock_controller
    import cpu_clk_pkg::*;
#(
    parameter int CNT_WIDTH   = 28,
    parameter int DEFAULT_DIV = 50000,
    parameter int DB_CYCLES   = 50000
) (
    input logic                   clock_in,
    input logic                   reset_n,
    cpu_clock_controller_if.slave bus
);
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] div_q, div_d;
    logic                 cpu_en_q, cpu_en_d;
    logic [EN_CNT_W-1:0]  en_count_q, en_count_d;
    logic                 step_pulse;
    logic                 terminal;

    step_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_step_db (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .btn_raw    (bus.step_btn),
        .step_pulse (step_pulse)
    );

    assign terminal = (cnt_q == div_q - CNT_WIDTH'(1));

    // Next-state, period counter, divisor and pulse decision.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        cpu_en_d   = 1'b0;
        en_count_d = en_count_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = bus.run_sw ? ST_RUN : ST_STEP;
                cnt_d   = '0;
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                    cnt_d   = '0;
                end else if (!bus.run_sw) begin
                    state_d = ST_STEP;
                    cnt_d   = '0;
                end else if (bus.div_load) begin
                    cnt_d = '0;
                end else if (terminal) begin
                    cpu_en_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_STEP: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (bus.run_sw) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (step_pulse) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (bus.resume && !bus.halt_req) begin
                    state_d = bus.run_sw ? ST_RUN : ST_STEP;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A divisor load applies in every state and restarts the period.
        if (bus.div_load) begin
            div_d = (bus.div_value < CNT_WIDTH'(MIN_DIV)) ? CNT_WIDTH'(MIN_DIV) : bus.div_value;
            cnt_d = '0;
        end

        if (cpu_en_d) begin
            en_count_d = en_count_q + EN_CNT_W'(1);
        end
    end

    // Controller registers; all outputs come straight from here.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= CNT_WIDTH'(DEFAULT_DIV);
            cpu_en_q   <= 1'b0;
            en_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            cpu_en_q   <= cpu_en_d;
            en_count_q <= en_count_d;
        end
    end

    assign bus.cpu_en   = cpu_en_q;
    assign bus.state    = state_q;
    assign bus.en_count = en_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench for cpu_clock_controller with a pulse scoreboard: the stimulus
// thread queues the cycle and en_count of each pulse it expects, a monitor pops
// and compares whenever cpu_en is seen high.
module tb_cpu_clock_controller;
    import cpu_clk_pkg::*;

    localparam int R = 3;       // cycle in which reset is released
    localparam int S = R + 62;  // start of the step-button scenario
    localparam int W = S + 34;  // start of the count-wrap scenario

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    cpu_clock_controller_if #(.CNT_WIDTH(28)) bus ();

    cpu_clock_controller #(
        .CNT_WIDTH   (28),
        .DEFAULT_DIV (5),
        .DB_CYCLES   (4)
    ) dut (
        .clock_in (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic expect_pulse(input int c, input logic [15:0] cnt);
        exp_t e;
        e.cyc = c;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare every observed pulse against the head of the queue.
    always @(negedge clk) begin
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            check("missed_pulse", 32'(cyc), 32'(exp_q[0].cyc));
            void'(exp_q.pop_front());
        end
        if (bus.cpu_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(bus.cpu_en), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_en_count", 32'(bus.en_count), 32'(e.cnt));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got cycle %0d, required finish before cycle 10000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n       = 1'b0;
        bus.run_sw    = 1'b1;
        bus.step_btn  = 1'b0;
        bus.halt_req  = 1'b0;
        bus.resume    = 1'b0;
        bus.div_value = '0;
        bus.div_load  = 1'b0;
        @(negedge clk);

        // Reset values, then release into RUN at the default divisor of 5.
        goto(R);
        check("reset_state", 32'(bus.state), 32'(ST_IDLE));
        check("reset_cpu_en", 32'(bus.cpu_en), 32'd0);
        check("reset_en_count", 32'(bus.en_count), 32'd0);
        reset_n = 1'b1;
        expect_pulse(R + 6, 16'd1);
        expect_pulse(R + 11, 16'd2);
        expect_pulse(R + 16, 16'd3);
        expect_pulse(R + 21, 16'd4);
        goto(R + 1);
        check("idle_to_run", 32'(bus.state), 32'(ST_RUN));
        goto(R + 21);
        check("en_count_after_run", 32'(bus.en_count), 32'd4);

        // Halt on terminal count, resume ignored while halt_req is held.
        goto(R + 25);
        bus.halt_req = 1'b1;
        goto(R + 26);
        check("halted", 32'(bus.state), 32'(ST_HALTED));
        goto(R + 28);
        bus.resume = 1'b1;
        goto(R + 29);
        bus.resume = 1'b0;
        goto(R + 30);
        check("resume_blocked_by_halt", 32'(bus.state), 32'(ST_HALTED));
        goto(R + 31);
        bus.halt_req = 1'b0;
        bus.resume   = 1'b1;
        expect_pulse(R + 37, 16'd5);
        expect_pulse(R + 42, 16'd6);
        goto(R + 32);
        bus.resume = 1'b0;
        check("resumed_to_run", 32'(bus.state), 32'(ST_RUN));

        // Button pressed during RUN must be discarded.
        goto(R + 44);
        bus.step_btn = 1'b1;

        // Load divisor 0 on a terminal-count cycle: clamp to 2, pulse suppressed.
        goto(R + 46);
        bus.div_load  = 1'b1;
        bus.div_value = '0;
        expect_pulse(R + 49, 16'd7);
        expect_pulse(R + 51, 16'd8);
        goto(R + 47);
        bus.div_load = 1'b0;

        // Back to divisor 5, again loaded on a terminal-count cycle.
        goto(R + 52);
        bus.step_btn  = 1'b0;
        bus.div_load  = 1'b1;
        bus.div_value = 28'd5;
        goto(R + 53);
        bus.div_load = 1'b0;

        // Drop run_sw with the counter at 3.
        goto(R + 56);
        bus.run_sw = 1'b0;
        goto(R + 57);
        check("run_to_step", 32'(bus.state), 32'(ST_STEP));
        goto(R + 58);
        check("no_pulse_after_switch", 32'(bus.cpu_en), 32'd0);

        // Bouncing press 1-0-1 then held: one pulse 7 cycles after the last rise.
        goto(S);
        bus.step_btn = 1'b1;
        expect_pulse(S + 9, 16'd9);
        goto(S + 1);
        bus.step_btn = 1'b0;
        goto(S + 2);
        bus.step_btn = 1'b1;
        goto(S + 20);
        bus.step_btn = 1'b0;

        // Preload the pulse counter just below the wrap point.
        goto(S + 30);
        force dut.en_count_q = 16'hFFFD;
        goto(S + 32);
        release dut.en_count_q;
        goto(S + 33);
        check("en_count_preload", 32'(bus.en_count), 32'h0000_FFFD);

        // Divisor 1 clamps to 2; three pulses carry the count through 0xFFFF to 0.
        goto(W);
        bus.run_sw    = 1'b1;
        bus.div_load  = 1'b1;
        bus.div_value = 28'd1;
        expect_pulse(W + 3, 16'hFFFE);
        expect_pulse(W + 5, 16'hFFFF);
        expect_pulse(W + 7, 16'h0000);
        goto(W + 1);
        bus.div_load = 1'b0;
        goto(W + 7);
        bus.run_sw = 1'b0;
        goto(W + 8);
        check("wrap_then_step", 32'(bus.state), 32'(ST_STEP));
        goto(W + 12);
        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        check("en_count_wrapped", 32'(bus.en_count), 32'd0);

        // Asynchronous reset takes effect without a clock edge.
        reset_n = 1'b0;
        #1;
        check("async_reset_state", 32'(bus.state), 32'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
